// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and requester IDs for the memory access arbiter.
// Ports: none (package).
// Configuration: MEM_ARB_RR_EN selects round-robin arbitration in the importing modules.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} state_t;
    typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: picks one requester from the I/D request pair, one-hot grant out.
// Ports: req_i  - request vector, bit REQ_I = fetch, bit REQ_D = data
//        last_i - requester granted most recently (used only for round-robin)
//        gnt_o  - one-hot grant, same bit order as req_i
// Configuration: MEM_ARB_RR_EN defined -> round-robin; undefined -> fixed priority D over I.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_i,
    output logic [1:0] gnt_o
);
    logic pick_d;
`ifdef MEM_ARB_RR_EN
    // On a tie, D wins only if I was the last owner.
    assign pick_d = req_i[REQ_D] && (!req_i[REQ_I] || last_i == REQ_I);
`else
    logic unused_last;
    assign unused_last = last_i;
    assign pick_d      = req_i[REQ_D];
`endif
    assign gnt_o = {pick_d, req_i[REQ_I] && !pick_d};
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one downstream memory port between a fetch (I) and a data (D) requester.
// Ports: CLK, RST (sync, active-high)
//        I_*  - fetch read request, one-cycle read-valid/data return, stall
//        D_*  - data read/write request, one-cycle read-valid/data return, stall
//        M_*  - downstream port: enables/addresses/write data out; loading, read-valid, data in
// Configuration: MEM_ARB_RR_EN defined -> round-robin with a last-grant flag; undefined -> D over I.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_RDEN,
    input  logic [ADDR_W-1:0] I_RADDR,
    output logic              I_RVALID,
    output logic [DATA_W-1:0] I_RDATA,
    output logic              I_STALL,
    input  logic              D_RDEN,
    input  logic [ADDR_W-1:0] D_RADDR,
    input  logic              D_WREN,
    input  logic [ADDR_W-1:0] D_WADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_STALL,
    output logic              M_RDEN,
    output logic [ADDR_W-1:0] M_RIADDR,
    output logic              M_WREN,
    output logic [ADDR_W-1:0] M_WADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic              M_LOADING,
    input  logic              M_RVALID,
    input  logic [ADDR_W-1:0] M_ROADDR,
    input  logic [DATA_W-1:0] M_RDATA
);
    state_t            state_q, state_d;
    req_id_t           owner_q, owner_d, last_g;
    logic              first_q, first_d, rden_q, rden_d, wren_q, wren_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        req, gnt;
    logic              granted, draining, rd_done, unused_roaddr;

    assign req           = {D_RDEN || D_WREN, I_RDEN};
    assign unused_roaddr = ^M_ROADDR;

`ifdef MEM_ARB_RR_EN
    req_id_t last_q;
    always_ff @(posedge CLK)
        if (RST)
            last_q <= REQ_I;
        else if (state_q == IDLE && |gnt)
            last_q <= owner_d;
    assign last_g = last_q;
`else
    assign last_g = REQ_I;
`endif

    mem_arb_select u_select (
        .req_i (req),
        .last_i(last_g),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        first_d = 1'b0;
        rden_d  = rden_q;
        wren_d  = wren_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d = gnt[REQ_D] ? GRANT_D : GRANT_I;
                owner_d = gnt[REQ_D] ? REQ_D : REQ_I;
                first_d = 1'b1;
                rden_d  = gnt[REQ_D] ? D_RDEN : 1'b1;
                wren_d  = gnt[REQ_D] && D_WREN;
                raddr_d = gnt[REQ_D] ? D_RADDR : I_RADDR;
                waddr_d = gnt[REQ_D] ? D_WADDR : '0;
                wdata_d = gnt[REQ_D] ? D_WDATA : '0;
            end
            // The first grant cycle ignores M_LOADING so memory has a cycle to react.
            GRANT_I, GRANT_D: if (!first_q && !M_LOADING) state_d = DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= REQ_I;
            first_q <= 1'b0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            first_q <= first_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign granted  = state_q == GRANT_I || state_q == GRANT_D;
    assign draining = state_q == DRAIN;
    assign M_RDEN   = granted && rden_q;
    assign M_WREN   = granted && wren_q;
    assign M_RIADDR = granted ? raddr_q : '0;
    assign M_WADDR  = granted ? waddr_q : '0;
    assign M_WDATA  = granted ? wdata_q : '0;

    // Read data is only accepted from memory during the owner's DRAIN cycle.
    assign rd_done  = draining && rden_q && M_RVALID;
    assign I_RVALID = rd_done && owner_q == REQ_I;
    assign D_RVALID = rd_done && owner_q == REQ_D;
    assign I_RDATA  = I_RVALID ? M_RDATA : '0;
    assign D_RDATA  = D_RVALID ? M_RDATA : '0;
    assign I_STALL  = req[REQ_I] && !RST && !(draining && owner_q == REQ_I);
    assign D_STALL  = req[REQ_D] && !RST && !(draining && owner_q == REQ_D);
endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all address ports.
REQ-002 Parameter: DATA_W, 32, data width of all data ports.
REQ-003 Port: CLK  in  1  single clock; all logic on its rising edge.
REQ-004 Port: RST  in  1  reset, synchronous, active-high.
REQ-005 Ports, fetch requester (I): I_RDEN in 1 read request; I_RADDR in ADDR_W address; I_RVALID out 1 one-cycle data-valid; I_RDATA out DATA_W data; I_STALL out 1 pending, not yet served.
REQ-006 Ports, data requester (D): D_RDEN in 1; D_RADDR in ADDR_W; D_WREN in 1; D_WADDR in ADDR_W; D_WDATA in DATA_W; D_RVALID out 1; D_RDATA out DATA_W; D_STALL out 1.
REQ-007 Ports, downstream memory port: M_RDEN out 1; M_RIADDR out ADDR_W; M_WREN out 1; M_WADDR out ADDR_W; M_WDATA out DATA_W; M_LOADING in 1 transfer in progress; M_RVALID in 1; M_ROADDR in ADDR_W; M_RDATA in DATA_W.

Function
REQ-008 The block SHALL share one downstream port between I and D, with exactly one owner at a time.
REQ-009 FSM states SHALL be IDLE, GRANT_I, GRANT_D, DRAIN.
REQ-010 IDLE: if any request, SHALL go to the winning grant state next cycle, capturing that requester's address/data/enables into registers; else stay.
REQ-011 Default arbitration SHALL be fixed priority, D over I.
REQ-012 GRANT_x: M_RDEN/M_WREN/addresses/M_WDATA SHALL be driven from the captured registers, held constant for the whole grant.
REQ-013 GRANT_x SHALL go to DRAIN on the first cycle M_LOADING is low, no earlier than the second grant cycle.
REQ-014 DRAIN: M_RDEN/M_WREN deasserted; if a read was granted, M_RVALID SHALL be routed to the owner's xRVALID with xRDATA=M_RDATA in the same cycle; then IDLE.
REQ-015 A write-only D grant SHALL complete in DRAIN with D_RVALID=0.
REQ-016 D_RDEN and D_WREN together SHALL be issued as one grant, both enables set.
REQ-017 xRVALID SHALL be high for exactly one cycle per granted read; xRDATA SHALL be 0 when xRVALID=0.
REQ-018 xSTALL SHALL be high while x requests and is not in its completing DRAIN cycle.
REQ-019 A request dropped mid-grant SHALL NOT abort the transfer; the result is discarded by the requester.
REQ-020 Nothing SHALL be granted on the DRAIN cycle; back-to-back grants are separated by at least one IDLE cycle.
REQ-021 M_RVALID outside DRAIN SHALL be ignored.

Reset
REQ-022 RST SHALL force IDLE, clear captured registers, and drive all outputs to 0, taking effect on the next edge even mid-grant.
REQ-023 After RST releases, the first grant SHALL follow REQ-011 regardless of pre-reset history.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, grant the requester not granted last; a last-grant flag resets to I, so D wins first.
REQ-025 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-011; no last-grant flag is built.

Structure
REQ-026 FSM state encodings and the requester IDs SHALL live in shared package mem_arb_pkg.
REQ-027 Grant selection SHALL be a sub-module mem_arb_select (requests plus last-grant in, one-hot grant out); the FSM and muxing stay in the top.

Verification
REQ-028 I_RDEN=1, I_RADDR=0x100, M_LOADING high 3 cycles -> M_RDEN=1 with M_RIADDR=0x100; in DRAIN, M_RDATA=0xDEADBEEF gives I_RVALID=1 for 1 cycle and I_RDATA=0xDEADBEEF.
REQ-029 I and D read the same cycle (0x100, 0x200) -> D granted first; I granted after the IDLE gap; each RVALID pulses once, never to the wrong requester.
REQ-030 D_WREN=1, D_WADDR=0x40, D_WDATA=0x12345678 -> M_WREN held with those values until M_LOADING low; D_RVALID stays 0; D_STALL drops in DRAIN.
REQ-031 RST asserted in cycle 2 of GRANT_I -> next cycle IDLE, all outputs 0; no I_RVALID.
REQ-032 MEM_ARB_RR_EN defined, I and D requesting continuously for 4 grants -> grant order D, I, D, I.
REQ-033 I_RDEN dropped mid-grant -> transfer completes, I_RVALID still pulses once, then IDLE.
